// File: rtl/axi_mem_pkg.sv
// Shared AXI4 encodings and FSM state type for the line master and its helpers.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam logic [3:0] CACHE_NORMAL = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_XFER = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RESP    = 3'd5
    } line_state_e;

    // A single-beat line still needs a one-bit counter.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/axi_line_beat_buf.sv
// Line-wide data register: whole-line load for writes, beat-indexed fill for reads,
// beat-indexed read mux to drain write bursts.
module axi_line_beat_buf #(
    parameter int DATA_W = 128,
    parameter int LINE_W = 512,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              beat_we_i,
    input  logic [CNT_W-1:0]  beat_idx_i,
    input  logic [DATA_W-1:0] beat_i,
    output logic [LINE_W-1:0] line_o,
    output logic [DATA_W-1:0] beat_o
);

    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk) begin
        if (load_i) begin
            line_q <= line_i;
        end else if (beat_we_i) begin
            line_q[int'(beat_idx_i)*DATA_W +: DATA_W] <= beat_i;
        end
    end

    assign line_o = line_q;
    assign beat_o = line_q[int'(beat_idx_i)*DATA_W +: DATA_W];

endmodule

// File: rtl/axi_line_master.sv
// Converts one cache-line read/write request into a single AXI4 INCR burst and
// returns one line-wide response; one transaction in flight at a time.
module axi_line_master
    import axi_mem_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 12,
    parameter int C_AXI_DATA_WIDTH = 128,
    parameter int LINE_WIDTH       = 512,
    parameter int ID_WIDTH         = 1,
    parameter int AXI_ID           = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [LINE_WIDTH-1:0]         req_wdata,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_we,
    output logic                          resp_err,
    output logic [LINE_WIDTH-1:0]         resp_rdata,
    output logic [ID_WIDTH-1:0]           m_axi_awid,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awlock,
    output logic [3:0]                    m_axi_awcache,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [ID_WIDTH-1:0]           m_axi_bid,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [ID_WIDTH-1:0]           m_axi_arid,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arlock,
    output logic [3:0]                    m_axi_arcache,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [ID_WIDTH-1:0]           m_axi_rid,
    input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int BEATS = LINE_WIDTH / C_AXI_DATA_WIDTH;
    localparam int CNT_W = beat_cnt_width(BEATS);
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~(C_AXI_ADDR_WIDTH'((1 << OFF_W) - 1));
    localparam logic [7:0] AXLEN  = 8'(BEATS - 1);
    localparam logic [2:0] AXSIZE = 3'($clog2(C_AXI_DATA_WIDTH / 8));

    line_state_e                 state_q;
    logic                        req_ready_q, resp_valid_q, we_q, err_q;
    logic                        arvalid_q, awvalid_q, wvalid_q, bready_q, rready_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;

    logic req_accept, last_beat, r_fire, aw_ok, w_ok;
    logic unused_ids;

    assign req_accept = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign last_beat  = (cnt_q == LAST_BEAT);
    assign r_fire     = (state_q == ST_RD_DATA) && m_axi_rvalid && rready_q;
    // Write phase is done when AW is (or just got) accepted and the final W beat is (or just got) accepted.
    assign aw_ok      = !awvalid_q || m_axi_awready;
    assign w_ok       = !wvalid_q || (m_axi_wready && last_beat);
    assign addr_d     = req_addr & ADDR_MASK;
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    axi_line_beat_buf #(
        .DATA_W (C_AXI_DATA_WIDTH),
        .LINE_W (LINE_WIDTH),
        .CNT_W  (CNT_W)
    ) u_buf (
        .clk        (clk),
        .load_i     (req_accept && req_we),
        .line_i     (req_wdata),
        .beat_we_i  (r_fire),
        .beat_idx_i (cnt_q),
        .beat_i     (m_axi_rdata),
        .line_o     (resp_rdata),
        .beat_o     (m_axi_wdata)
    );

    always_ff @(posedge clk) begin
        if (req_accept) begin
            addr_q <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            rready_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_accept) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        err_q       <= 1'b0;
                        cnt_q       <= '0;
                        if (req_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_XFER;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_fire) begin
                        if (m_axi_rresp != RESP_OKAY) err_q <= 1'b1;
                        // Burst end is counter-driven; rlast only feeds the framing check.
                        if (last_beat) begin
                            if (!m_axi_rlast) err_q <= 1'b1;
                            rready_q     <= 1'b0;
                            resp_valid_q <= 1'b1;
                            cnt_q        <= '0;
                            state_q      <= ST_RESP;
                        end else begin
                            if (m_axi_rlast) err_q <= 1'b1;
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_WR_XFER: begin
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi_wready) begin
                        if (last_beat) begin
                            wvalid_q <= 1'b0;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    if (aw_ok && w_ok) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != RESP_OKAY) err_q <= 1'b1;
                        bready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_we    = we_q;
    assign resp_err   = err_q;

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = AXLEN;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_NORMAL;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = last_beat;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = AXLEN;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = CACHE_NORMAL;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
